// File: rtl/seq_detect_arbiter.sv
// Two-channel round-robin word serializer feeding a per-channel 010110 detector.
// Each channel keeps its own bit history, so interleaved words never form false matches.
module seq_detect_arbiter #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clr,
   input  logic              i_mode,
   input  logic              i_req0_valid,
   input  logic [WORD_W-1:0] i_req0_data,
   output logic              o_req0_ready,
   input  logic              i_req1_valid,
   input  logic [WORD_W-1:0] i_req1_data,
   output logic              o_req1_ready,
   output logic              o_busy,
   output logic              o_grant,
   output logic              o_match,
   output logic              o_match_src,
   output logic [CNT_W-1:0]  o_cnt0,
   output logic [CNT_W-1:0]  o_cnt1
);

   localparam int               BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
   localparam logic [5:0]       PATTERN   = 6'b010110;
   localparam logic [2:0]       HIST_FULL = 3'd5;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  r_state;
   logic [WORD_W-1:0]       r_word;
   logic [BIT_W-1:0]        r_bit;
   logic                    r_mode;
   logic                    r_grant;
   logic                    r_busy;
   logic                    r_match;
   logic                    r_match_src;
   // Five previous bits per channel plus how many of them are real history.
   logic [1:0][4:0]         r_hist;
   logic [1:0][2:0]         r_len;
   logic [1:0][CNT_W-1:0]   r_cnt;

   logic       w_any;
   logic       w_pick;
   logic       w_accept;
   logic       w_shift;
   logic       w_bit;
   logic       w_hit;
   logic [4:0] w_hist;
   logic [2:0] w_len;

   always_comb begin
      w_any    = i_req0_valid | i_req1_valid;
      w_pick   = (i_req0_valid & i_req1_valid) ? ~r_grant : i_req1_valid;
      w_accept = i_reset & (r_state == IDLE) & w_any;
      w_shift  = (r_state == SHIFT);
      w_bit    = r_word[WORD_W-1];
      w_hist   = r_hist[r_grant];
      w_len    = r_len[r_grant];
      // A bit arriving alongside clr opens a fresh history, so it can never complete a match.
      w_hit    = w_shift & ~i_clr & (w_len == HIST_FULL) & ({w_hist, w_bit} == PATTERN);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= IDLE;
         r_word      <= '0;
         r_bit       <= '0;
         r_mode      <= 1'b0;
         r_grant     <= 1'b1;
         r_busy      <= 1'b0;
         r_match     <= 1'b0;
         r_match_src <= 1'b0;
         r_hist      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
      end else begin
         r_match     <= w_hit;
         r_match_src <= w_hit & r_grant;

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= SHIFT;
                  r_busy  <= 1'b1;
                  r_grant <= w_pick;
                  r_word  <= w_pick ? i_req1_data : i_req0_data;
                  r_mode  <= i_mode;
                  r_bit   <= '0;
               end
            end
            SHIFT: begin
               r_word <= r_word << 1;
               r_bit  <= r_bit + BIT_W'(1);
               if (r_bit == LAST_BIT) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (i_clr) begin
            r_hist <= '0;
            r_len  <= '0;
            if (w_shift) begin
               r_hist[r_grant] <= {4'b0000, w_bit};
               r_len[r_grant]  <= 3'd1;
            end
         end else if (w_shift) begin
            if (w_hit && r_mode) begin
               r_hist[r_grant] <= '0;
               r_len[r_grant]  <= '0;
            end else begin
               r_hist[r_grant] <= {w_hist[3:0], w_bit};
               if (w_len != HIST_FULL)
                  r_len[r_grant] <= w_len + 3'd1;
            end
         end

         if (i_clr)
            r_cnt <= '0;
         else if (w_hit && (r_cnt[r_grant] != {CNT_W{1'b1}}))
            r_cnt[r_grant] <= r_cnt[r_grant] + CNT_W'(1);
      end
   end

   assign o_req0_ready = w_accept & ~w_pick;
   assign o_req1_ready = w_accept &  w_pick;
   assign o_busy       = r_busy;
   assign o_grant      = r_grant;
   assign o_match      = r_match;
   assign o_match_src  = r_match_src;
   assign o_cnt0       = r_cnt[0];
   assign o_cnt1       = r_cnt[1];

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the arbitration, serialization and detection rules.
module tb_seq_detect_arbiter;

   localparam int WORD_W = 8;
   localparam int CNT_W  = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n, clr, mode, v0, v1;
   logic [WORD_W-1:0] d0, d1;
   logic              r0, r1, busy, grant, match, msrc;
   logic [CNT_W-1:0]  cnt0, cnt1;

   int ntests = 0, nfail = 0, cyc_n = 0;
   int last_acc = -1, last_match = -1;
   bit acc_seen;
   int acc_log[$];
   int acc_cyc[$];

   // Model state: bits still to serialize, per-channel histories, counters.
   bit qb[$];
   bit h0[$];
   bit h1[$];
   int m_ch = 0, m_mode = 0, m_last = 1, c0 = 0, c1 = 0, m_src = 0;
   bit m_match = 0;

   logic [7:0] pats [4] = '{8'h58, 8'h5A, 8'h16, 8'h2C};

   always #5 clk = ~clk;

   seq_detect_arbiter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(reset_n), .i_clr(clr), .i_mode(mode),
      .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0),
      .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1),
      .o_busy(busy), .o_grant(grant), .o_match(match), .o_match_src(msrc),
      .o_cnt0(cnt0), .o_cnt1(cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_ch();
      if (v0 && v1) return 1 - m_last;
      return v1 ? 1 : 0;
   endfunction

   task automatic model_reset();
      qb.delete(); h0.delete(); h1.delete();
      c0 = 0; c1 = 0; m_last = 1; m_match = 0; m_src = 0;
   endtask

   task automatic hist_step(input int ch, input bit b, input int md, output bit hit);
      bit h[$];
      bit [5:0] w;
      if (ch == 0) h = h0; else h = h1;
      h.push_back(b);
      if (h.size() > 6) void'(h.pop_front());
      hit = 0;
      if (h.size() == 6) begin
         for (int i = 0; i < 6; i++) w[5-i] = h[i];
         hit = (w == 6'b010110);
      end
      if (hit && md == 1) h.delete();
      if (ch == 0) h0 = h; else h1 = h;
   endtask

   task automatic model_edge();
      bit idle;
      bit b;
      bit hit;
      int p;
      b = 0; hit = 0;
      if (!reset_n) begin model_reset(); return; end
      idle = (qb.size() == 0);
      if (!idle) begin
         b = qb.pop_front();
         hist_step(m_ch, b, m_mode, hit);
      end
      if (clr) begin
         h0.delete(); h1.delete(); hit = 0;
         if (!idle) begin
            if (m_ch == 0) h0.push_back(b); else h1.push_back(b);
         end
         c0 = 0; c1 = 0;
      end else if (hit) begin
         if (m_ch == 0 && c0 < CMAX) c0++;
         else if (m_ch == 1 && c1 < CMAX) c1++;
      end
      m_match = hit;
      m_src   = hit ? m_ch : 0;
      if (idle && (v0 || v1)) begin
         p = pick_ch();
         for (int i = WORD_W - 1; i >= 0; i--) qb.push_back(p ? d1[i] : d0[i]);
         m_ch = p; m_mode = mode; m_last = p;
      end
   endtask

   // One clock: check all outputs at the falling edge, then advance the model on the rising edge.
   task automatic cyc();
      bit idle;
      int p;
      logic e0, e1;
      @(negedge clk);
      idle = (qb.size() == 0);
      p    = pick_ch();
      e0   = reset_n && idle && (v0 || v1) && (p == 0);
      e1   = reset_n && idle && (v0 || v1) && (p == 1);
      chk("ready0", r0, e0);
      chk("ready1", r1, e1);
      chk("busy", busy, !idle);
      chk("grant", grant, m_last);
      chk("match", match, m_match);
      if (m_match) chk("match_src", msrc, m_src);
      chk("cnt0", cnt0, c0);
      chk("cnt1", cnt1, c1);
      acc_seen = (r0 === 1'b1) || (r1 === 1'b1);
      if (acc_seen) begin
         last_acc = cyc_n;
         acc_log.push_back((r1 === 1'b1) ? 1 : 0);
         acc_cyc.push_back(cyc_n);
      end
      if (match === 1'b1) last_match = cyc_n;
      @(posedge clk);
      model_edge();
      cyc_n++;
      #1;
   endtask

   task automatic set_reset(input logic v);
      reset_n = v;
      if (!v) model_reset();
   endtask

   task automatic send(input int ch, input logic [7:0] d, input logic md);
      int n;
      n = 0;
      mode = md;
      if (ch == 0) begin v0 = 1; d0 = d; end else begin v1 = 1; d1 = d; end
      do begin cyc(); n++; end while (!acc_seen && n < 30);
      chk("send_accept", acc_seen, 1);
      v0 = 0; v1 = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin cyc(); n++; end
      chk("drain_timeout", busy, 0);
      cyc(); cyc();
   endtask

   task automatic clr_pulse();
      clr = 1; cyc(); clr = 0; cyc();
   endtask

   initial begin
      int a;
      v0 = 0; v1 = 0; d0 = '0; d1 = '0; mode = 0; clr = 0;
      set_reset(0);
      cyc(); cyc();
      chk("rst_grant", grant, 1);
      chk("rst_busy", busy, 0);
      set_reset(1);
      cyc();

      // Simple match, mode=1
      last_match = -1;
      send(0, 8'b01011000, 1'b1);
      a = last_acc;
      drain();
      chk("simple_latency", last_match - a, 7);
      chk("simple_cnt0", cnt0, 1);

      // Overlap in both modes
      clr_pulse();
      send(0, 8'b01011010, 1'b0); send(0, 8'b11000000, 1'b0); drain();
      chk("overlap_m0_cnt0", cnt0, 2);
      clr_pulse();
      send(0, 8'b01011010, 1'b1); send(0, 8'b11000000, 1'b1); drain();
      chk("overlap_m1_cnt0", cnt0, 1);

      // Context isolation across interleaved channels
      clr_pulse();
      send(0, 8'b00000101, 1'b0); send(1, 8'hFF, 1'b0);
      last_match = -1;
      send(0, 8'b10000000, 1'b0);
      a = last_acc;
      drain();
      chk("iso_match_bit1", last_match - a, 3);
      chk("iso_cnt0", cnt0, 1);
      chk("iso_cnt1", cnt1, 0);

      // Round-robin with both channels held valid from reset
      set_reset(0); cyc(); set_reset(1);
      acc_log.delete(); acc_cyc.delete();
      v0 = 1; v1 = 1; d0 = 8'h5A; d1 = 8'h16; mode = 0;
      repeat (4 * (WORD_W + 1)) cyc();
      v0 = 0; v1 = 0;
      chk("arb_count", acc_log.size(), 4);
      for (int i = 0; i < acc_log.size() && i < 4; i++) begin
         chk($sformatf("arb_grant%0d", i), acc_log[i], i % 2);
         if (i > 0) chk($sformatf("arb_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], WORD_W + 1);
      end
      drain();

      // Reset three cycles into SHIFT, then a clean word from its MSB
      send(0, 8'hA5, 1'b0);
      cyc(); cyc(); cyc();
      v0 = 1; d0 = 8'b01011000; mode = 1;
      set_reset(0);
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_match", match, 0);
      chk("mid_rst_src", msrc, 0);
      chk("mid_rst_grant", grant, 1);
      chk("mid_rst_ready0", r0, 0);
      chk("mid_rst_cnt0", cnt0, 0);
      cyc(); cyc();
      set_reset(1);
      last_match = -1;
      send(0, 8'b01011000, 1'b1);
      a = last_acc;
      drain();
      chk("post_rst_latency", last_match - a, 7);
      chk("post_rst_cnt0", cnt0, 1);

      // Saturation then clear
      clr_pulse();
      for (int k = 0; k < CMAX + 5; k++) send(0, 8'b01011000, 1'b1);
      drain();
      chk("sat_cnt0", cnt0, 8'hFF);
      clr = 1; cyc(); clr = 0;
      chk("clr_cnt0", cnt0, 0);
      chk("clr_cnt1", cnt1, 0);

      // Random traffic against the model
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(0, 199) == 0) set_reset(0);
         else if (!reset_n) set_reset(1);
         v0   = 1'($urandom_range(0, 1));
         v1   = 1'($urandom_range(0, 1));
         d0   = ($urandom_range(0, 1) == 1) ? pats[$urandom_range(0, 3)] : 8'($urandom);
         d1   = ($urandom_range(0, 1) == 1) ? pats[$urandom_range(0, 3)] : 8'($urandom);
         mode = 1'($urandom_range(0, 1));
         clr  = ($urandom_range(0, 24) == 0);
         cyc();
      end
      clr = 0; v0 = 0; v1 = 0;
      set_reset(1);
      drain();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 Parameter WORD_W, default 8, sets the width of a request word (bits, >= 2).
REQ-002 Parameter CNT_W, default 8, sets the width of a per-channel match counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of counters and stream histories.
REQ-006 mode  input  1  1 = non-overlapping detection, 0 = overlapping detection.
REQ-007 req0_valid  input  1  channel 0 offers a word.
REQ-008 req0_data  input  WORD_W  channel 0 word, serialized MSB first.
REQ-009 req0_ready  output  1  channel 0 word accepted this cycle.
REQ-010 req1_valid, req1_data, req1_ready  same widths and meanings as channel 0, for channel 1.
REQ-011 busy  output  1  a word is being serialized.
REQ-012 grant  output  1  channel owning the current or most recent word.
REQ-013 match  output  1  one-cycle pulse per detected 010110.
REQ-014 match_src  output  1  channel that produced the current match pulse.
REQ-015 cnt0, cnt1  output  CNT_W  per-channel match counts.

Function
REQ-016 The block SHALL implement the states IDLE and SHIFT.
REQ-017 In IDLE, the block SHALL accept a word when any reqN_valid is high: it pulses that reqN_ready high in the same cycle, latches the word and mode, and goes to SHIFT.
REQ-018 Arbitration SHALL be round-robin: with both channels valid, the block grants the channel not granted last; with one valid, it grants that channel; after reset, channel 0 has priority.
REQ-019 In SHIFT, the block SHALL process one bit per cycle, MSB first, for exactly WORD_W cycles, then return to IDLE.
REQ-020 Throughput SHALL be one word per WORD_W+1 cycles.
REQ-021 reqN_ready SHALL never be high outside IDLE.
REQ-022 Each channel SHALL keep its own stream history, saved across words and across interleaving with the other channel.
REQ-023 A match SHALL occur when the six most recent bits of the granted channel's history, oldest first, equal 010110.
REQ-024 In mode=1, that channel's history SHALL be emptied after a match; in mode=0, it SHALL be retained, so matches may share one bit.
REQ-025 mode SHALL be sampled at word acceptance and held for the whole word.
REQ-026 If accept happens in cycle T, bit k SHALL be processed in cycle T+1+k; a match completed by bit k SHALL drive match=1 and match_src=grant in cycle T+2+k.
REQ-027 On each match, the counter of the source channel SHALL increment and saturate at all-ones.
REQ-028 clr SHALL zero both counters and both histories in the next cycle without disturbing the FSM; the bit processed in the clr cycle starts the new history.
REQ-029 busy SHALL be 1 exactly in SHIFT.
REQ-030 grant SHALL hold its value while in IDLE.

Reset
REQ-031 While reset is 0, the block SHALL force: state IDLE, busy=0, match=0, match_src=0, grant=1 (so channel 0 wins first), cnt0=cnt1=0, histories empty, req0_ready=req1_ready=0.
REQ-032 A reset asserted mid-SHIFT SHALL discard the in-flight word and suppress any pending match pulse.

Verification
REQ-033 Simple match: req0 word 8'b01011000 accepted at T, mode=1 -> match=1, match_src=0 at T+7; cnt0=1; busy falls after T+8.
REQ-034 Overlap: req0 words 8'b01011010 then 8'b11000000, mode=0 -> cnt0=2; repeat with mode=1 -> cnt0=1.
REQ-035 Context isolation: req0 8'b00000101, then req1 8'hFF, then req0 8'b10000000 -> one match in req0's second word, at bit index 1; cnt0=1, cnt1=0.
REQ-036 Arbitration: req0_valid and req1_valid held high from reset -> grants 0,1,0,1, with ready pulses 9 cycles apart.
REQ-037 Reset mid-word: reset driven low 3 cycles into SHIFT -> all outputs equal the REQ-031 values; after release, the next word is serialized from its MSB.
REQ-038 Clear and saturation: force cnt0 to 255 matches -> cnt0 holds 8'hFF; then clr=1 for one cycle -> cnt0=cnt1=0 the next cycle.
